mem_ctrl: RTL and testbench

Memory controller that sits directly below the data cache and the load/store buffer's IO path. It turns whole-line cache refills and write-backs into byte-serial RAM transfers, and it performs single-byte IO accesses. Refilled lines, write-back acknowledgements and IO results are returned as one-cycle pulses.

---
 rtl/mem_ctrl_pkg.sv | 23 ++
 rtl/mem_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller and the data cache above it:
// transfer states, default line geometry and the IO address decode.
package mem_ctrl_pkg;

    localparam int BLOCK_WIDTH_DEF = 4;
    localparam int BLOCK_SIZE_DEF  = 2 ** BLOCK_WIDTH_DEF;

    // IO space is selected by address bits [17:16]
    localparam logic [1:0] IO_ADDR_SEL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LINE_READ,
        ST_LINE_WRITE,
        ST_IO_READ,
        ST_IO_WRITE
    } state_e;

    function automatic logic is_io_addr(input logic [31:0] addr);
        return addr[17:16] == IO_ADDR_SEL;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: serialises cache line refills / write-backs into
// byte-wide RAM transfers and performs single-byte IO reads and writes.
// Completion is signalled with one-cycle pulses; no new request is taken
// in a pulse cycle so the requester can drop or change its request.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEF,
    parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
    input  logic                      clkIn,
    input  logic                      resetIn,
    input  logic                      readyIn,
    input  logic                      clearIn,
    input  logic                      lineReq,
    input  logic                      lineRead,
    input  logic [31:BLOCK_WIDTH]     lineAddr,
    input  logic [BLOCK_SIZE*8-1:0]   lineWriteData,
    output logic                      lineDataValid,
    output logic [31:BLOCK_WIDTH]     lineAddrOut,
    output logic [BLOCK_SIZE*8-1:0]   lineDataOut,
    output logic                      lineWriteAccept,
    input  logic                      ioReq,
    input  logic                      ioRead,
    input  logic [31:0]               ioAddr,
    input  logic [7:0]                ioWriteData,
    output logic                      ioDataValid,
    output logic [31:0]               ioDataOut,
    output logic                      ioWriteSuc,
    input  logic [7:0]                memIn,
    output logic [7:0]                memOut,
    output logic [31:0]               memAddrOut,
    output logic                      memWriteOut,
    input  logic                      ioBufferFull
);

    localparam logic [BLOCK_WIDTH:0] CNT_FULL = (BLOCK_WIDTH + 1)'(BLOCK_SIZE);
    localparam logic [BLOCK_WIDTH:0] CNT_LAST = (BLOCK_WIDTH + 1)'(BLOCK_SIZE - 1);

    state_e                     state_q, state_d;
    // next byte index to issue; capture index is always one behind
    logic [BLOCK_WIDTH:0]       cnt_q, cnt_d;
    // memIn this cycle holds the byte addressed in the previous issue
    logic                       cap_q, cap_d;
    logic [BLOCK_SIZE*8-1:0]    line_q, line_d;
    logic [31:BLOCK_WIDTH]      laddr_q, laddr_d;
    logic [31:0]                io_addr_q, io_addr_d;
    logic [7:0]                 io_wdata_q, io_wdata_d;
    logic [31:0]                io_data_q, io_data_d;
    logic                       line_valid_q, line_valid_d;
    logic                       line_acc_q, line_acc_d;
    logic                       io_valid_q, io_valid_d;
    logic                       io_suc_q, io_suc_d;

    logic                       pulse_busy;
    logic                       cap_en;
    logic [BLOCK_WIDTH-1:0]     iss_idx;
    logic [BLOCK_WIDTH-1:0]     cap_idx;

    assign iss_idx    = cnt_q[BLOCK_WIDTH-1:0];
    assign cap_idx    = BLOCK_WIDTH'(cnt_q - 1'b1);
    assign pulse_busy = line_valid_q | line_acc_q | io_valid_q | io_suc_q;

    // Next-state logic: acceptance, transfer sequencing and byte capture
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_d        = cap_q;
        line_d       = line_q;
        laddr_d      = laddr_q;
        io_addr_d    = io_addr_q;
        io_wdata_d   = io_wdata_q;
        io_data_d    = io_data_q;
        line_valid_d = 1'b0;
        line_acc_d   = 1'b0;
        io_valid_d   = 1'b0;
        io_suc_d     = 1'b0;
        cap_en       = 1'b0;

        if (readyIn) begin
            case (state_q)
                ST_IDLE: begin
                    if (!pulse_busy) begin
                        if (lineReq) begin
                            laddr_d = lineAddr;
                            cnt_d   = '0;
                            cap_d   = 1'b0;
                            if (lineRead) begin
                                state_d = ST_LINE_READ;
                            end else begin
                                state_d = ST_LINE_WRITE;
                                line_d  = lineWriteData;
                            end
                        end else if (ioReq) begin
                            io_addr_d  = ioAddr;
                            io_wdata_d = ioWriteData;
                            cap_d      = 1'b0;
                            state_d    = ioRead ? ST_IO_READ : ST_IO_WRITE;
                        end
                    end
                end
                ST_LINE_READ: begin
                    cap_en = cap_q;
                    if (cnt_q == CNT_FULL) begin
                        state_d      = ST_IDLE;
                        cap_d        = 1'b0;
                        line_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        cap_d = 1'b1;
                    end
                end
                ST_LINE_WRITE: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d    = ST_IDLE;
                        line_acc_d = 1'b1;
                    end
                end
                ST_IO_READ: begin
                    if (clearIn) begin
                        state_d = ST_IDLE;
                        cap_d   = 1'b0;
                    end else if (cap_q) begin
                        io_data_d  = {24'b0, memIn};
                        state_d    = ST_IDLE;
                        cap_d      = 1'b0;
                        io_valid_d = 1'b1;
                    end else begin
                        cap_d = 1'b1;
                    end
                end
                ST_IO_WRITE: begin
                    if (!ioBufferFull) begin
                        state_d  = ST_IDLE;
                        io_suc_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (cap_en) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                if (cap_idx == i[BLOCK_WIDTH-1:0]) begin
                    line_d[i*8 +: 8] = memIn;
                end
            end
        end
    end

    // RAM port drive. While frozen with a byte in flight, the last issued
    // address is held so memIn is valid for that byte on resume.
    always_comb begin
        memAddrOut  = '0;
        memOut      = '0;
        memWriteOut = 1'b0;
        case (state_q)
            ST_LINE_READ: begin
                if (cap_q && (!readyIn || cnt_q == CNT_FULL)) begin
                    memAddrOut = {laddr_q, cap_idx};
                end else begin
                    memAddrOut = {laddr_q, iss_idx};
                end
            end
            ST_LINE_WRITE: begin
                memAddrOut  = {laddr_q, iss_idx};
                memWriteOut = readyIn;
                for (int i = 0; i < BLOCK_SIZE; i++) begin
                    if (iss_idx == i[BLOCK_WIDTH-1:0]) begin
                        memOut = line_q[i*8 +: 8];
                    end
                end
            end
            ST_IO_READ: begin
                memAddrOut = io_addr_q;
            end
            ST_IO_WRITE: begin
                memAddrOut  = io_addr_q;
                memOut      = io_wdata_q;
                memWriteOut = readyIn && !ioBufferFull;
            end
            default: ;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cap_q        <= 1'b0;
            line_q       <= '0;
            laddr_q      <= '0;
            io_addr_q    <= '0;
            io_wdata_q   <= '0;
            io_data_q    <= '0;
            line_valid_q <= 1'b0;
            line_acc_q   <= 1'b0;
            io_valid_q   <= 1'b0;
            io_suc_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cap_q        <= cap_d;
            line_q       <= line_d;
            laddr_q      <= laddr_d;
            io_addr_q    <= io_addr_d;
            io_wdata_q   <= io_wdata_d;
            io_data_q    <= io_data_d;
            line_valid_q <= line_valid_d;
            line_acc_q   <= line_acc_d;
            io_valid_q   <= io_valid_d;
            io_suc_q     <= io_suc_d;
        end
    end

    assign lineDataValid   = line_valid_q;
    assign lineWriteAccept = line_acc_q;
    assign lineAddrOut     = laddr_q;
    assign lineDataOut     = line_q;
    assign ioDataValid     = io_valid_q;
    assign ioWriteSuc      = io_suc_q;
    assign ioDataOut       = io_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios followed by random
// line/IO transactions, checked against a byte-addressed RAM model and the
// cycle latencies of each transfer type.
module tb_mem_ctrl;

    localparam int BW = 4;
    localparam int BS = 16;

    logic              clk = 1'b0;
    logic              resetIn, readyIn, clearIn;
    logic              lineReq, lineRead;
    logic [31:BW]      lineAddr;
    logic [BS*8-1:0]   lineWriteData;
    logic              lineDataValid, lineWriteAccept;
    logic [31:BW]      lineAddrOut;
    logic [BS*8-1:0]   lineDataOut;
    logic              ioReq, ioRead;
    logic [31:0]       ioAddr;
    logic [7:0]        ioWriteData;
    logic              ioDataValid, ioWriteSuc;
    logic [31:0]       ioDataOut;
    logic [7:0]        memIn, memOut;
    logic [31:0]       memAddrOut;
    logic              memWriteOut;
    logic              ioBufferFull;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.BLOCK_WIDTH(BW), .BLOCK_SIZE(BS)) dut (
        .clkIn(clk), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn),
        .lineReq(lineReq), .lineRead(lineRead), .lineAddr(lineAddr),
        .lineWriteData(lineWriteData), .lineDataValid(lineDataValid),
        .lineAddrOut(lineAddrOut), .lineDataOut(lineDataOut),
        .lineWriteAccept(lineWriteAccept), .ioReq(ioReq), .ioRead(ioRead),
        .ioAddr(ioAddr), .ioWriteData(ioWriteData), .ioDataValid(ioDataValid),
        .ioDataOut(ioDataOut), .ioWriteSuc(ioWriteSuc), .memIn(memIn),
        .memOut(memOut), .memAddrOut(memAddrOut), .memWriteOut(memWriteOut),
        .ioBufferFull(ioBufferFull)
    );

    // RAM model: sparse storage, deterministic fill for untouched bytes
    logic [7:0] ram [bit [31:0]];

    function automatic logic [7:0] ram_peek(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    initial memIn = 8'h00;
    always @(posedge clk) begin
        memIn <= ram_peek(memAddrOut);
        if (memWriteOut) ram[memAddrOut] = memOut;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pulses();
        return {lineDataValid, lineWriteAccept, ioDataValid, ioWriteSuc};
    endfunction

    // One line transfer from its accept cycle (0) to its pulse cycle.
    // readyIn is low for st_len cycles from st_start; each low cycle
    // delays every later event by one cycle.
    task automatic run_line(input bit rd, input logic [31:BW] la, input logic [BS*8-1:0] wd,
                            input int st_start, input int st_len, input bit hold, input bit with_io);
        logic [BS*8-1:0] exp_line;
        int p, stalls, idx;
        for (int k = 0; k < BS; k++) exp_line[k*8 +: 8] = ram_peek({la, k[BW-1:0]});
        p = (rd ? BS + 2 : BS + 1) + st_len;
        step();
        lineReq = 1'b1; lineRead = rd; lineAddr = la; lineWriteData = wd;
        ioReq = with_io; readyIn = 1'b1; clearIn = 1'($urandom_range(0, 1));
        #1;
        chk("line_c0_we", memWriteOut, 1'b0);
        chk("line_c0_pulses", pulses(), 4'b0000);
        stalls = 0;
        for (int c = 1; c <= p; c++) begin
            step();
            readyIn = !(st_len > 0 && c >= st_start && c < st_start + st_len);
            clearIn = 1'($urandom_range(0, 1));
            #1;
            idx = c - 1 - stalls;
            if (readyIn && idx >= 0 && idx < BS) begin
                chk("line_addr", memAddrOut, {la, idx[BW-1:0]});
                if (!rd) chk("line_wbyte", memOut, wd[idx*8 +: 8]);
            end
            chk("line_we", memWriteOut, !rd && readyIn && idx >= 0 && idx < BS);
            chk("line_pulses", pulses(), (c == p) ? (rd ? 4'b1000 : 4'b0100) : 4'b0000);
            if (!readyIn) stalls++;
        end
        chk("line_addr_out", lineAddrOut, la);
        if (rd) chk("line_data", lineDataOut, exp_line);
        if (!hold) lineReq = 1'b0;
        clearIn = 1'b0;
        $display("line %s addr=%h stall=%0d+%0d pulse_cycle=%0d", rd ? "refill" : "writeback",
                 la, st_start, st_len, p);
    endtask

    // One IO access from its accept cycle; clear_at>0 aborts a read then
    task automatic run_io(input bit rd, input logic [31:0] a, input logic [7:0] wd,
                          input int full_n, input int clear_at);
        logic [7:0] exp_b;
        int p;
        exp_b = ram_peek(a);
        step();
        ioReq = 1'b1; ioRead = rd; ioAddr = a; ioWriteData = wd;
        ioBufferFull = (full_n > 0); clearIn = 1'b0; readyIn = 1'b1;
        #1;
        chk("io_c0_we", memWriteOut, 1'b0);
        chk("io_c0_pulses", pulses(), 4'b0000);
        if (!rd) begin
            p = 2 + full_n;
            for (int c = 1; c <= p; c++) begin
                step();
                ioBufferFull = (c <= full_n);
                clearIn = 1'($urandom_range(0, 1));
                #1;
                chk("iow_we", memWriteOut, c == 1 + full_n);
                if (c == 1 + full_n) begin
                    chk("iow_addr", memAddrOut, a);
                    chk("iow_byte", memOut, wd);
                end
                chk("iow_pulses", pulses(), (c == p) ? 4'b0001 : 4'b0000);
            end
        end else begin
            p = (clear_at > 0) ? clear_at : 3;
            for (int c = 1; c <= p; c++) begin
                step();
                clearIn = (c == clear_at);
                #1;
                if (c == 1) chk("ior_addr", memAddrOut, a);
                chk("ior_we", memWriteOut, 1'b0);
                chk("ior_pulses", pulses(), (c == 3) ? 4'b0010 : 4'b0000);
                if (c == 3) chk("ior_data", ioDataOut, {24'b0, exp_b});
            end
        end
        ioReq = 1'b0;
        ioBufferFull = 1'b0;
        $display("io %s addr=%h wdata=%h full=%0d clear=%0d end_cycle=%0d", rd ? "read" : "write",
                 a, wd, full_n, clear_at, p);
    endtask

    initial begin
        logic [31:BW] la;
        logic [BS*8-1:0] wd;
        logic [31:0] ia;
        int kind;

        resetIn = 1'b1; readyIn = 1'b1; clearIn = 1'b0;
        lineReq = 1'b0; lineRead = 1'b0; lineAddr = '0; lineWriteData = '0;
        ioReq = 1'b0; ioRead = 1'b0; ioAddr = '0; ioWriteData = '0; ioBufferFull = 1'b0;
        for (int k = 0; k < BS; k++) ram[32'h100 + k] = 8'(k);

        step(); step();
        chk("rst_pulses", pulses(), 4'b0000);
        chk("rst_line_addr", lineAddrOut, '0);
        chk("rst_line_data", lineDataOut, '0);
        chk("rst_io_data", ioDataOut, '0);
        chk("rst_mem_addr", memAddrOut, '0);
        chk("rst_mem_out", memOut, '0);
        chk("rst_mem_we", memWriteOut, 1'b0);
        resetIn = 1'b0;

        // refill of 0x100..0x10F, pattern bytes 0x00..0x0F
        run_line(1'b1, 28'h0000010, '0, 0, 0, 1'b0, 1'b0);
        chk("refill_literal", lineDataOut, 128'h0F0E0D0C0B0A09080706050403020100);

        // write-back to 0x200, request held through the pulse cycle
        run_line(1'b0, 28'h0000020, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0, 0, 0, 1'b1, 1'b0);

        // simultaneous line and IO requests: line first, IO right after the pulse
        ioRead = 1'b1; ioAddr = 32'h0003_0000; ioWriteData = 8'h00;
        run_line(1'b1, 28'h0000020, '0, 0, 0, 1'b0, 1'b1);
        chk("wb_landed", lineDataOut, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
        run_io(1'b1, 32'h0003_0000, 8'h00, 0, 0);

        // IO write with three buffer-full cycles, aborted read, then read-back
        run_io(1'b0, 32'h0003_0000, 8'h41, 3, 0);
        run_io(1'b1, 32'h0003_0000, 8'h00, 0, 2);
        run_io(1'b1, 32'h0003_0000, 8'h00, 0, 0);
        chk("io_readback", ioDataOut, 32'h41);

        // refill frozen for two cycles once byte 5 is in flight
        run_line(1'b1, 28'h0000010, '0, 7, 2, 1'b0, 1'b0);

        // random traffic over a small pool of lines and IO bytes
        for (int t = 0; t < 14; t++) begin
            kind = $urandom_range(0, 3);
            la = 28'h0000100 + 28'($urandom_range(0, 3));
            wd = {$urandom, $urandom, $urandom, $urandom};
            ia = {14'h0, 2'b11, 8'h00, 8'($urandom_range(0, 3))};
            case (kind)
                0: run_line(1'b1, la, '0, $urandom_range(1, 17), $urandom_range(0, 3), 1'b0, 1'b0);
                1: run_line(1'b0, la, wd, $urandom_range(1, 16), $urandom_range(0, 3), 1'b0, 1'b0);
                2: run_io(1'b1, ia, 8'h00, 0, $urandom_range(0, 2));
                default: run_io(1'b0, ia, 8'($urandom), $urandom_range(0, 4), 0);
            endcase
        end

        // reset in the middle of a refill: no pulse, registers cleared
        step();
        lineReq = 1'b1; lineRead = 1'b1; lineAddr = 28'h0000010; readyIn = 1'b1;
        step();
        lineReq = 1'b0;
        for (int c = 0; c < 4; c++) step();
        resetIn = 1'b1;
        step();
        resetIn = 1'b0;
        #1;
        chk("midrst_line_data", lineDataOut, '0);
        chk("midrst_line_addr", lineAddrOut, '0);
        for (int c = 0; c < 20; c++) begin
            step();
            chk("midrst_pulses", pulses(), 4'b0000);
        end
        chk("midrst_mem_addr", memAddrOut, '0);
        $display("reset mid-refill: abandoned");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
